// File: rtl/iq_age_scheduler.sv
// Oldest-first select/allocate controller for the issue queue: valid bits, ROB tags and an NxN age matrix.
// Optional IQ_SEL_STATS_EN adds saturating issue/stall counters (stat_issued, stat_stall).
module iq_age_scheduler #(
    parameter int N_ENTRY  = 4,
    parameter int ROB_SIZE = 8,
    localparam int IDX_W   = $clog2(N_ENTRY),
    localparam int ROB_W   = $clog2(ROB_SIZE)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_valid,
    input  logic [ROB_W-1:0]    alloc_rob_idx,
    output logic                alloc_ok,
    output logic [IDX_W-1:0]    alloc_idx,
    input  logic [N_ENTRY-1:0]  req_ready,
    output logic                grant_valid,
    output logic [IDX_W-1:0]    grant_idx,
    output logic [N_ENTRY-1:0]  grant_onehot,
    input  logic                issue_accept,
    input  logic                flush,
    input  logic [ROB_SIZE-1:0] flush_mask,
    output logic [N_ENTRY-1:0]  entry_valid,
    output logic [IDX_W:0]      occupancy
`ifdef IQ_SEL_STATS_EN
    ,
    output logic [31:0]         stat_issued,
    output logic [31:0]         stat_stall
`endif
);

    logic [N_ENTRY-1:0]                valid;
    logic [N_ENTRY-1:0]                valid_nxt;
    logic [N_ENTRY-1:0][N_ENTRY-1:0]   older;
    logic [N_ENTRY-1:0][N_ENTRY-1:0]   older_nxt;
    logic [N_ENTRY-1:0][ROB_W-1:0]     tag;
    logic [N_ENTRY-1:0]                cand;
    logic [N_ENTRY-1:0]                win;
    logic [N_ENTRY-1:0]                issue_clr;
    logic [N_ENTRY-1:0]                flush_clr;
    logic [N_ENTRY-1:0]                clr;
    logic                              alloc_take;
    logic                              issued;

    assign entry_valid = valid;
    assign alloc_ok    = |(~valid);
    assign cand        = valid & req_ready;
    assign grant_valid = |cand;
    assign issued      = grant_valid & issue_accept;

    always_comb begin
        alloc_idx = '0;
        for (int unsigned i = N_ENTRY; i > 0; i--) begin
            if (!valid[i-1]) alloc_idx = IDX_W'(i - 1);
        end
    end

    // Entry i wins when no other candidate is recorded as older than it.
    always_comb begin
        win       = '0;
        grant_idx = '0;
        for (int unsigned i = 0; i < N_ENTRY; i++) begin
            win[i] = cand[i];
            for (int unsigned j = 0; j < N_ENTRY; j++) begin
                if (cand[j] && older[j][i]) win[i] = 1'b0;
            end
            if (win[i]) grant_idx = IDX_W'(i);
        end
        grant_onehot = win;
    end

    always_comb begin
        occupancy = '0;
        for (int unsigned i = 0; i < N_ENTRY; i++) begin
            occupancy = occupancy + (IDX_W+1)'(valid[i]);
        end
    end

    always_comb begin
        issue_clr = issued ? win : '0;
        flush_clr = '0;
        for (int unsigned i = 0; i < N_ENTRY; i++) begin
            flush_clr[i] = flush & valid[i] & flush_mask[tag[i]];
        end
        clr        = issue_clr | flush_clr;
        alloc_take = alloc_valid & alloc_ok & ~(flush & flush_mask[alloc_rob_idx]);
        valid_nxt  = valid & ~clr;
        older_nxt  = older;
        if (alloc_take) begin
            valid_nxt[alloc_idx] = 1'b1;
            older_nxt[alloc_idx] = '0;
            // Survivors of this cycle become older than the new entry.
            for (int unsigned j = 0; j < N_ENTRY; j++) begin
                older_nxt[j][alloc_idx] = valid[j] & ~clr[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            older <= '0;
            tag   <= '0;
        end else begin
            valid <= valid_nxt;
            older <= older_nxt;
            if (alloc_take) tag[alloc_idx] <= alloc_rob_idx;
        end
    end

`ifdef IQ_SEL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (issued && stat_issued != '1) stat_issued <= stat_issued + 32'd1;
            if ((|valid) && !grant_valid && stat_stall != '1) stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_iq_age_scheduler.sv
// Directed self-checking bench for iq_age_scheduler (stat counters checked when IQ_SEL_STATS_EN is defined).
module tb_iq_age_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       alloc_valid;
    logic [2:0] alloc_rob_idx;
    logic       alloc_ok;
    logic [1:0] alloc_idx;
    logic [3:0] req_ready;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic [3:0] grant_onehot;
    logic       issue_accept;
    logic       flush;
    logic [7:0] flush_mask;
    logic [3:0] entry_valid;
    logic [2:0] occupancy;
`ifdef IQ_SEL_STATS_EN
    logic [31:0] stat_issued;
    logic [31:0] stat_stall;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    iq_age_scheduler #(.N_ENTRY(4), .ROB_SIZE(8)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_rob_idx(alloc_rob_idx),
        .alloc_ok(alloc_ok), .alloc_idx(alloc_idx),
        .req_ready(req_ready),
        .grant_valid(grant_valid), .grant_idx(grant_idx), .grant_onehot(grant_onehot),
        .issue_accept(issue_accept),
        .flush(flush), .flush_mask(flush_mask),
        .entry_valid(entry_valid), .occupancy(occupancy)
`ifdef IQ_SEL_STATS_EN
        , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid   = 1'b0;
        alloc_rob_idx = '0;
        req_ready     = '0;
        issue_accept  = 1'b0;
        flush         = 1'b0;
        flush_mask    = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic do_alloc(input logic [2:0] t, input logic [1:0] exp_slot);
        alloc_valid   = 1'b1;
        alloc_rob_idx = t;
        #1;
        check("alloc_idx", 32'(alloc_idx), 32'(exp_slot));
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic expect_grant(input string name, input logic [1:0] idx);
        #1;
        check({name, "_gv"}, 32'(grant_valid), 32'd1);
        check({name, "_gidx"}, 32'(grant_idx), 32'(idx));
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;

        // reset values
        check("rst_alloc_ok", 32'(alloc_ok), 32'd1);
        check("rst_alloc_idx", 32'(alloc_idx), 32'd0);
        check("rst_grant_valid", 32'(grant_valid), 32'd0);
        check("rst_grant_idx", 32'(grant_idx), 32'd0);
        check("rst_grant_onehot", 32'(grant_onehot), 32'd0);
        check("rst_entry_valid", 32'(entry_valid), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);

        // 1: three allocations drained in order
        do_alloc(3'd5, 2'd0);
        do_alloc(3'd6, 2'd1);
        do_alloc(3'd7, 2'd2);
        check("t1_occ3", 32'(occupancy), 32'd3);
        req_ready = 4'b0111;
        issue_accept = 1'b1;
        expect_grant("t1_g0", 2'd0);
        check("t1_onehot0", 32'(grant_onehot), 32'b0001);
        tick();
        expect_grant("t1_g1", 2'd1);
        tick();
        expect_grant("t1_g2", 2'd2);
        tick();
        check("t1_gv_end", 32'(grant_valid), 32'd0);
        check("t1_onehot_end", 32'(grant_onehot), 32'd0);
        check("t1_occ_end", 32'(occupancy), 32'd0);
        idle();

        // 2: age order after re-use of a middle slot
        do_reset();
        do_alloc(3'd1, 2'd0);
        do_alloc(3'd2, 2'd1);
        do_alloc(3'd4, 2'd2);
        do_alloc(3'd5, 2'd3);
        req_ready = 4'b0010;
        issue_accept = 1'b1;
        expect_grant("t2_issue1", 2'd1);
        tick();
        idle();
        do_alloc(3'd3, 2'd1);
        req_ready = 4'b1111;
        issue_accept = 1'b1;
        expect_grant("t2_o0", 2'd0);
        tick();
        expect_grant("t2_o1", 2'd2);
        tick();
        expect_grant("t2_o2", 2'd3);
        tick();
        expect_grant("t2_o3", 2'd1);
        check("t2_onehot3", 32'(grant_onehot), 32'b0010);
        tick();
        check("t2_occ_end", 32'(occupancy), 32'd0);
        idle();

        // 3: full queue, simultaneous issue and alloc drops the alloc
        do_reset();
        do_alloc(3'd0, 2'd0);
        do_alloc(3'd1, 2'd1);
        do_alloc(3'd2, 2'd2);
        do_alloc(3'd3, 2'd3);
        check("t3_full_ok", 32'(alloc_ok), 32'd0);
        check("t3_full_occ", 32'(occupancy), 32'd4);
        req_ready = 4'b0001;
        issue_accept = 1'b1;
        alloc_valid = 1'b1;
        alloc_rob_idx = 3'd6;
        tick();
        idle();
        #1;
        check("t3_ok_after", 32'(alloc_ok), 32'd1);
        check("t3_occ_after", 32'(occupancy), 32'd3);
        check("t3_ev_after", 32'(entry_valid), 32'b1110);
        check("t3_aidx_after", 32'(alloc_idx), 32'd0);
        // reset with a populated queue
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t3_midrst_ev", 32'(entry_valid), 32'd0);
        check("t3_midrst_occ", 32'(occupancy), 32'd0);

        // 4: flush overlapping an accepted grant
        do_alloc(3'd1, 2'd0);
        do_alloc(3'd2, 2'd1);
        do_alloc(3'd3, 2'd2);
        do_alloc(3'd4, 2'd3);
        req_ready = 4'b0100;
        issue_accept = 1'b1;
        flush = 1'b1;
        flush_mask = 8'b0001_1000;
        expect_grant("t4_g", 2'd2);
        tick();
        idle();
        #1;
        check("t4_occ", 32'(occupancy), 32'd2);
        check("t4_ev", 32'(entry_valid), 32'b0011);
        // masked alloc under flush is dropped
        alloc_valid = 1'b1;
        alloc_rob_idx = 3'd4;
        flush = 1'b1;
        flush_mask = 8'b0001_0000;
        tick();
        idle();
        #1;
        check("t4_drop_ev", 32'(entry_valid), 32'b0011);
        check("t4_drop_occ", 32'(occupancy), 32'd2);

        // 5: oldest not ready, stable grant while stalled
        do_reset();
        do_alloc(3'd0, 2'd0);
        do_alloc(3'd1, 2'd1);
        do_alloc(3'd2, 2'd2);
        req_ready = 4'b0110;
        issue_accept = 1'b0;
        for (int c = 0; c < 3; c++) begin
            expect_grant("t5_hold", 2'd1);
            tick();
        end
        check("t5_occ", 32'(occupancy), 32'd3);
        req_ready = 4'b0111;
        expect_grant("t5_oldest", 2'd0);
        check("t5_onehot", 32'(grant_onehot), 32'b0001);
        issue_accept = 1'b1;
        tick();
        expect_grant("t5_next", 2'd1);
        idle();

`ifdef IQ_SEL_STATS_EN
        // 6: statistics counters
        do_reset();
        do_alloc(3'd0, 2'd0);
        for (int c = 0; c < 4; c++) tick();
        req_ready = 4'b0001;
        issue_accept = 1'b1;
        tick();
        idle();
        for (int c = 0; c < 9; c++) begin
            do_alloc(3'(c), 2'd0);
            req_ready = 4'b0001;
            issue_accept = 1'b1;
            tick();
            idle();
        end
        check("t6_issued", stat_issued, 32'd10);
        check("t6_stall", stat_stall, 32'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_issued", stat_issued, 32'd0);
        check("t6_rst_stall", stat_stall, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
